// File: rtl/ysyx_22041071_booth_mul_if.sv
// rtl/ysyx_22041071_booth_mul_if.sv - request/response bundle for the radix-4 Booth multiplier
// Ports (master = requester, slave = multiplier):
//   flush                              abandon any operation in flight
//   mul_valid / mul_ready              request handshake
//   mul_signed, mulw, mul1, mul2       request payload (signedness, word mode, operands)
//   out_valid / out_ready              result handshake
//   result_h, result_l                 product high / low halves
interface ysyx_22041071_booth_mul_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            mul_valid;
  logic            mul_ready;
  logic [1:0]      mul_signed;
  logic            mulw;
  logic [XLEN-1:0] mul1;
  logic [XLEN-1:0] mul2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_h;
  logic [XLEN-1:0] result_l;

  modport master (
    output flush, mul_valid, mul_signed, mulw, mul1, mul2, out_ready,
    input  mul_ready, out_valid, result_h, result_l
  );

  modport slave (
    input  flush, mul_valid, mul_signed, mulw, mul1, mul2, out_ready,
    output mul_ready, out_valid, result_h, result_l
  );
endinterface

// File: rtl/ysyx_22041071_booth_mul.sv
// rtl/ysyx_22041071_booth_mul.sv - iterative radix-4 Booth multiplier, one digit per cycle
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    ysyx_22041071_booth_mul_if.slave (request, flush and result handshakes)
module ysyx_22041071_booth_mul #(
  parameter int XLEN = 64
) (
  input  logic clk,
  input  logic reset,
  ysyx_22041071_booth_mul_if.slave bus
);
  localparam int H  = XLEN / 2;
  localparam int MW = XLEN + 2;       // extended multiplier width (even)
  localparam int AW = 2 * XLEN + 4;   // accumulator width
  localparam int CW = $clog2(H + 1);

  // Index of the final digit: XLEN/2 in full mode, XLEN/4 in word mode.
  localparam logic [CW-1:0] LAST_FULL = CW'(H);
  localparam logic [CW-1:0] LAST_WORD = CW'(H / 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;    // multiplicand, pre-shifted by 2 bits per retired digit
  logic [MW-1:0]   mplier;   // multiplier, shifted right by 2 bits per retired digit
  logic            mprev;    // bit below the current digit window
  logic [CW-1:0]   cnt;
  logic            word;
  logic [XLEN-1:0] res_h;
  logic [XLEN-1:0] res_l;

  logic            accept;
  logic            last;
  logic            s1, s2;
  logic [AW-1:0]   ext1;
  logic [MW-1:0]   ext2;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   acc_sum;
  logic [XLEN-1:0] res_h_nxt;
  logic [XLEN-1:0] res_l_nxt;

  assign bus.mul_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result_h  = res_h;
  assign bus.result_l  = res_l;

  assign accept = (state == IDLE) && bus.mul_valid && !bus.flush;
  assign last   = (cnt == (word ? LAST_WORD : LAST_FULL));

  // Operand extension: the sign bit is replicated only when that operand is signed.
  always_comb begin
    s1 = bus.mul_signed[1];
    s2 = (bus.mul_signed == 2'b11);
    if (bus.mulw) begin
      ext1 = {{(AW-H){s1 & bus.mul1[H-1]}}, bus.mul1[H-1:0]};
      ext2 = {{(MW-H){s2 & bus.mul2[H-1]}}, bus.mul2[H-1:0]};
    end else begin
      ext1 = {{(AW-XLEN){s1 & bus.mul1[XLEN-1]}}, bus.mul1};
      ext2 = {{(MW-XLEN){s2 & bus.mul2[XLEN-1]}}, bus.mul2};
    end
  end

  // Radix-4 Booth digit from {b(2i+1), b(2i), b(2i-1)}.
  always_comb begin
    pp = '0;
    case ({mplier[1:0], mprev})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    acc_sum = acc + pp;
  end

  always_comb begin
    if (word) begin
      res_l_nxt = {{H{acc_sum[H-1]}}, acc_sum[H-1:0]};
      res_h_nxt = {{H{acc_sum[XLEN-1]}}, acc_sum[XLEN-1:H]};
    end else begin
      res_l_nxt = acc_sum[XLEN-1:0];
      res_h_nxt = acc_sum[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.mul_valid) state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mprev  <= 1'b0;
      cnt    <= '0;
      word   <= 1'b0;
      res_h  <= '0;
      res_l  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc    <= '0;
        mcand  <= ext1;
        mplier <= ext2;
        mprev  <= 1'b0;
        cnt    <= '0;
        word   <= bus.mulw;
      end else if (state == BUSY && !bus.flush) begin
        acc    <= acc_sum;
        mcand  <= mcand << 2;
        mplier <= {mplier[MW-1], mplier[MW-1], mplier[MW-1:2]};
        mprev  <= mplier[1];
        cnt    <= cnt + 1'b1;
        if (last) begin
          res_h <= res_h_nxt;
          res_l <= res_l_nxt;
        end
      end else if (bus.flush) begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22041071_booth_mul.sv
// tb/tb_ysyx_22041071_booth_mul.sv - randomized self-checking bench for ysyx_22041071_booth_mul
module tb_ysyx_22041071_booth_mul;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  ysyx_22041071_booth_mul_if #(.XLEN(XLEN)) bus ();

  ysyx_22041071_booth_mul #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Exact product from plain signed arithmetic on wide values.
  function automatic logic [127:0] model(input logic [63:0] m1, input logic [63:0] m2,
                                         input logic [1:0] ms, input logic w);
    logic signed [131:0] a, b, p;
    if (w) begin
      a = ms[1]        ? {{100{m1[31]}}, m1[31:0]} : {100'b0, m1[31:0]};
      b = (ms == 2'b11) ? {{100{m2[31]}}, m2[31:0]} : {100'b0, m2[31:0]};
    end else begin
      a = ms[1]        ? {{68{m1[63]}}, m1} : {68'b0, m1};
      b = (ms == 2'b11) ? {{68{m2[63]}}, m2} : {68'b0, m2};
    end
    p = a * b;
    if (w) return {{32{p[63]}}, p[63:32], {32{p[31]}}, p[31:0]};
    return p[127:0];
  endfunction

  task automatic present(input logic [63:0] m1, input logic [63:0] m2,
                         input logic [1:0] ms, input logic w);
    bus.mul1       = m1;
    bus.mul2       = m2;
    bus.mul_signed = ms;
    bus.mulw       = w;
    bus.mul_valid  = 1'b1;
  endtask

  task automatic scramble();
    bus.mul_valid  = 1'b0;
    bus.mul1       = {$urandom, $urandom};
    bus.mul2       = {$urandom, $urandom};
    bus.mul_signed = 2'($urandom);
    bus.mulw       = 1'($urandom);
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that leaves DONE.
  task automatic do_op(input logic [63:0] m1, input logic [63:0] m2, input logic [1:0] ms,
                       input logic w, input logic [63:0] eh, input logic [63:0] el,
                       input int hold, input bit flush_done);
    int k;
    check("ready_before", 64'(bus.mul_ready), 64'd1);
    present(m1, m2, ms, w);
    @(posedge clk); #1;
    scramble();
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k + 1), w ? 64'(XLEN/4 + 2) : 64'(XLEN/2 + 2));
    check("result_h", bus.result_h, eh);
    check("result_l", bus.result_l, el);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_ready", 64'(bus.mul_ready), 64'd0);
      check("hold_h", bus.result_h, eh);
      check("hold_l", bus.result_l, el);
    end
    bus.out_ready = 1'b1;
    bus.flush     = flush_done;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    check("idle_ready", 64'(bus.mul_ready), 64'd1);
    check("idle_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic do_rand();
    logic [63:0] m1, m2;
    logic [1:0]  ms;
    logic        w;
    logic [127:0] e;
    int sel;
    m1 = {$urandom, $urandom};
    m2 = {$urandom, $urandom};
    sel = $urandom_range(0, 5);
    if (sel == 0) m1 = '1;
    if (sel == 1) m2 = 64'h8000_0000_8000_0000;
    if (sel == 2) m1 = '0;
    ms = 2'($urandom);
    w  = 1'($urandom);
    e  = model(m1, m2, ms, w);
    do_op(m1, m2, ms, w, e[127:64], e[63:0], $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.mul_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mul1      = '0;
    bus.mul2      = '0;
    bus.mul_signed = 2'b00;
    bus.mulw      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 64'(bus.mul_ready), 64'd1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_h", bus.result_h, 64'd0);
    check("rst_l", bus.result_l, 64'd0);

    // Directed products.
    do_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b11, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 0, 1'b0);
    do_op(64'h0000_0000_8000_0000, 64'd2, 2'b11, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1'b0);
    // Consumer stalls for 3 DONE cycles.
    do_op(64'd123456789, 64'd987654321, 2'b01, 1'b0,
          64'h0, 64'd121932631112635269, 3, 1'b0);

    // Flush in the 5th BUSY cycle: nothing completes, results keep the last product.
    present(64'd5, 64'd9, 2'b00, 1'b0);
    @(posedge clk); #1;
    scramble();
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_ready", 64'(bus.mul_ready), 64'd1);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_h", bus.result_h, 64'h0);
    check("flush_l", bus.result_l, 64'd121932631112635269);
    do_op(64'hFFFF_FFFF_FFFF_FFF6, 64'd10, 2'b11, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C, 0, 1'b0);

    // Flush beats mul_valid in IDLE.
    present(64'd3, 64'd3, 2'b00, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.mul_valid = 1'b0;
    check("flush_vs_valid", 64'(bus.mul_ready), 64'd1);

    // Flush beats out_ready in DONE; the next op still works.
    e = model(64'd77, 64'd11, 2'b00, 1'b0);
    do_op(64'd77, 64'd11, 2'b00, 1'b0, e[127:64], e[63:0], 1, 1'b1);
    e = model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0);
    do_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0,
          e[127:64], e[63:0], 0, 1'b0);

    for (int i = 0; i < 30; i++) do_rand();

    // Reset in the middle of an operation clears everything.
    present(64'd1000, 64'd1000, 2'b00, 1'b0);
    @(posedge clk); #1;
    scramble();
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.flush = 1'b0;
    check("midrst_ready", 64'(bus.mul_ready), 64'd1);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_h", bus.result_h, 64'd0);
    check("midrst_l", bus.result_l, 64'd0);
    e = model(64'd1000, 64'd1000, 2'b00, 1'b1);
    do_op(64'd1000, 64'd1000, 2'b00, 1'b1, e[127:64], e[63:0], 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22041071_booth_mul.md
YSYX_22041071_BOOTH_MUL -- requirements
Module: ysyx_22041071_booth_mul

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand width; XLEN SHALL be even and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1 bit: abandons any operation in flight.
REQ-005 SHALL have port mul_valid, input, 1 bit: a request is presented.
REQ-006 SHALL have port mul_ready, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port mul_signed, input, 2 bits: operand signedness.
- 2'b11: signed x signed.
- 2'b10: mul1 signed x mul2 unsigned.
- 2'b00 and 2'b01: unsigned x unsigned.
REQ-008 SHALL have port mulw, input, 1 bit: word mode, using the operand low halves (XLEN/2 bits).
REQ-009 SHALL have port mul1, input, XLEN bits: the multiplicand.
REQ-010 SHALL have port mul2, input, XLEN bits: the multiplier.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port result_h, output, XLEN bits: the high half of the product.
REQ-014 SHALL have port result_l, output, XLEN bits: the low half of the product.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 SHALL drive mul_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-017 SHALL accept a request on a cycle with mul_valid & mul_ready & !flush.
- On acceptance, operands and mode are latched and the state goes IDLE->BUSY.
- Input changes after acceptance SHALL have no effect on the result.
REQ-018 SHALL extend operands before the Booth loop.
- Full mode: operands sign- or zero-extended to XLEN+2 bits per mul_signed.
- Word mode: operand low XLEN/2 bits extended to XLEN/2+2 bits per mul_signed.
REQ-019 SHALL use a radix-4 Booth recode of the multiplier, retiring one 2-bit digit per BUSY cycle.
- Digit set {-2,-1,0,+1,+2}.
- The partial-product accumulator is at least 2*XLEN+4 bits wide.
REQ-020 SHALL run for N iterations, N = XLEN/2+1 in full mode and N = XLEN/4+1 in word mode, counted by an internal counter.
- BUSY->DONE when the counter reaches N-1.
REQ-021 SHALL have fixed latency: acceptance at edge T gives out_valid high from cycle T+N+1 (XLEN=64: T+34 full, T+18 word).
REQ-022 SHALL produce a full-mode result of result_h = product[2*XLEN-1:XLEN] and result_l = product[XLEN-1:0], the exact two's-complement product.
REQ-023 SHALL produce a word-mode result as follows.
- result_l = product[XLEN/2-1:0], sign-extended to XLEN.
- result_h = product[XLEN-1:XLEN/2], sign-extended to XLEN.
REQ-024 SHALL register result_h and result_l, load them on the BUSY->DONE transition, and hold them stable until the next BUSY->DONE load.
REQ-025 SHALL handle the DONE state as follows.
- DONE->IDLE on out_ready.
- Otherwise stay in DONE with out_valid held high and the results unchanged.
- mul_ready stays low while in DONE.
REQ-026 SHALL return to IDLE on the next edge when flush is high in any state.
- The counter is cleared, out_valid does not assert for the abandoned operation, and result registers are not updated.
REQ-027 SHALL give flush priority over mul_valid in the same cycle; the request is not accepted.
REQ-028 SHALL give flush priority over out_ready in DONE; the state goes to IDLE and the result is dropped.
REQ-029 SHALL allow a new request to be accepted in the first IDLE cycle after DONE or after a flush; there is no back-to-back acceptance from DONE.

Reset
REQ-030 SHALL, with reset high at an edge, set state to IDLE, counter to 0, and the accumulator, result_h and result_l to 0, regardless of the current state.
REQ-031 SHALL drive mul_ready=1 and out_valid=0 in the cycle after reset; reset takes priority over flush and mul_valid.

Verification (XLEN=64)
REQ-032 SHALL cover signed x signed: mul1=0xFFFFFFFFFFFFFFFD, mul2=7, mul_signed=11 -> out_valid at T+34, result_h=0xFFFFFFFFFFFFFFFF, result_l=0xFFFFFFFFFFFFFFEB.
REQ-033 SHALL cover unsigned max: mul1=mul2=0xFFFFFFFFFFFFFFFF, mul_signed=00 -> result_h=0xFFFFFFFFFFFFFFFE, result_l=0x0000000000000001.
REQ-034 SHALL cover signed x unsigned: mul1=0xFFFFFFFFFFFFFFFF, mul2=0xFFFFFFFFFFFFFFFF, mul_signed=10 -> result_h=0xFFFFFFFFFFFFFFFF, result_l=0x0000000000000001.
REQ-035 SHALL cover word mode: mulw=1, mul_signed=11, mul1=0x0000000080000000, mul2=2 -> out_valid at T+18, result_l=0, result_h=0xFFFFFFFFFFFFFFFF.
REQ-036 SHALL cover flush in the 5th BUSY cycle -> IDLE next cycle, no out_valid pulse, results unchanged; a new request is accepted the following cycle and returns the correct product.
REQ-037 SHALL cover out_ready held low for 3 DONE cycles -> out_valid, result_h and result_l stable, mul_ready=0; IDLE one edge after out_ready rises.
